// File: rtl/lock_supervisor.sv
// lock_supervisor: turns lock-FSM grants into a timed door pulse and
// enforces a timed lockout (siren + lock FSM reset) after MAX_FAILS alarms.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   openlock    unlock grant level from the lock FSM
//   alarm       wrong-code level from the lock FSM
//   door_unlock door actuator drive (registered)
//   siren       siren drive (registered)
//   lockout     lockout status (registered)
//   lock_rst    reset request to the lock FSM (registered)
//   fail_count  consecutive failed attempts (registered)
module lock_supervisor #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned UNLOCK_HOLD    = 8,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             openlock,
  input  logic             alarm,
  output logic             door_unlock,
  output logic             siren,
  output logic             lockout,
  output logic             lock_rst,
  output logic [CNT_W-1:0] fail_count
);

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_FAILS);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(UNLOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_UNLOCKED = 2'd1,
    S_LOCKOUT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             open_prev_q, alarm_prev_q;
  logic             door_q, door_d;
  logic             lock_q, lock_d;

  logic             open_rise;
  logic             alarm_rise;
  logic [CNT_W-1:0] fail_inc;

  assign open_rise  = openlock & ~open_prev_q;
  assign alarm_rise = alarm & ~alarm_prev_q;
  assign fail_inc   = fail_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE, S_UNLOCKED: begin
        if (alarm_rise) begin
          // alarm beats a simultaneous grant and aborts an open door
          if (fail_inc == MAX_C) begin
            state_d = S_LOCKOUT;
            timer_d = LOCK_C;
            fail_d  = '0;
          end else begin
            state_d = S_IDLE;
            timer_d = '0;
            fail_d  = fail_inc;
          end
        end else if (open_rise) begin
          state_d = S_UNLOCKED;
          timer_d = HOLD_C;
          fail_d  = '0;
        end else if (state_q == S_UNLOCKED) begin
          if (timer_q == '0) begin
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        fail_d  = '0;
      end
    endcase
  end

  // outputs are registered from the next state so they move on the
  // same edge that samples the event
  always_comb begin
    door_d = (state_d == S_UNLOCKED);
    lock_d = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      fail_q       <= '0;
      open_prev_q  <= 1'b0;
      alarm_prev_q <= 1'b0;
      door_q       <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fail_q       <= fail_d;
      open_prev_q  <= openlock;
      alarm_prev_q <= alarm;
      door_q       <= door_d;
      lock_q       <= lock_d;
    end
  end

  assign door_unlock = door_q;
  assign siren       = lock_q;
  assign lockout     = lock_q;
  assign lock_rst    = lock_q;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// tb_lock_supervisor: directed and random stimulus for lock_supervisor,
// compared every cycle against a remaining-cycles reference model.
module tb_lock_supervisor;

  localparam int MAXF  = 3;
  localparam int HOLD  = 8;
  localparam int LOCKC = 16;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          openlock = 1'b0;
  logic          alarm = 1'b0;
  logic          door_unlock;
  logic          siren;
  logic          lockout;
  logic          lock_rst;
  logic [CW-1:0] fail_count;

  int compared = 0;
  int mismatched = 0;

  // reference model: cycles of door / lockout still to run, fail tally
  int m_door_rem = 0;
  int m_lock_rem = 0;
  int m_fails = 0;
  bit m_po = 0;
  bit m_pa = 0;

  lock_supervisor #(
    .MAX_FAILS(MAXF), .UNLOCK_HOLD(HOLD),
    .LOCKOUT_CYCLES(LOCKC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .openlock(openlock), .alarm(alarm),
    .door_unlock(door_unlock), .siren(siren),
    .lockout(lockout), .lock_rst(lock_rst),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit orise, arise;
    orise = openlock && !m_po;
    arise = alarm && !m_pa;
    if (rst) begin
      m_door_rem = 0; m_lock_rem = 0; m_fails = 0;
      m_po = 0; m_pa = 0;
      return;
    end
    m_po = openlock;
    m_pa = alarm;
    if (m_lock_rem > 0) begin
      m_lock_rem--;
    end else if (arise) begin
      m_door_rem = 0;
      m_fails++;
      if (m_fails == MAXF) begin
        m_fails = 0;
        m_lock_rem = LOCKC;
      end
    end else if (orise) begin
      m_door_rem = HOLD;
      m_fails = 0;
    end else if (m_door_rem > 0) begin
      m_door_rem--;
    end
  endtask

  task automatic check(string tag, int obs, int exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s at %0t: observed %0d expected %0d",
             tag, $time, obs, exp_v);
    end
  endtask

  task automatic step(bit o, bit a, bit r);
    openlock = o;
    alarm = a;
    rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check("door_unlock", int'(door_unlock), int'(m_door_rem > 0));
    check("siren", int'(siren), int'(m_lock_rem > 0));
    check("lockout", int'(lockout), int'(m_lock_rem > 0));
    check("lock_rst", int'(lock_rst), int'(m_lock_rem > 0));
    check("fail_count", int'(fail_count), m_fails);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    // reset
    step(0, 0, 1);
    step(0, 0, 1);
    check("reset_fail", int'(fail_count), 0);
    idle(3);

    // single grant: exactly HOLD cycles of door
    step(1, 0, 0);
    idle(HOLD + 3);

    // three alarm pulses -> lockout for LOCKC cycles
    step(0, 1, 0); step(0, 0, 0);
    check("fail_after_1", int'(fail_count), 1);
    step(0, 1, 0); step(0, 0, 0);
    check("fail_after_2", int'(fail_count), 2);
    step(0, 1, 0);
    check("lock_entry", int'(lockout), 1);
    check("lock_fail0", int'(fail_count), 0);
    idle(LOCKC + 2);
    check("lock_exit", int'(lockout), 0);

    // held alarm counts once
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    check("held_alarm", int'(fail_count), 1);
    idle(2);

    // extend: second grant 5 cycles later
    step(1, 0, 0);
    idle(4);
    step(1, 0, 0);
    idle(HOLD + 2);

    // abort by alarm during unlock
    step(1, 0, 0);
    idle(2);
    step(0, 1, 0);
    check("abort_door", int'(door_unlock), 0);
    check("abort_fail", int'(fail_count), 1);
    idle(3);

    // reach lockout, toggle inputs inside it
    step(0, 1, 0); step(0, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < LOCKC - 2; i++) step(i[0], i[1], 0);
    step(1, 1, 0);
    step(1, 1, 0);
    check("no_stale_edge", int'(fail_count), 0);
    check("no_stale_door", int'(door_unlock), 0);
    idle(2);

    // simultaneous rise in idle counts as a fail
    step(1, 1, 0);
    check("simul_door", int'(door_unlock), 0);
    check("simul_fail", int'(fail_count), 1);
    idle(2);

    // reset in the middle of lockout
    step(0, 1, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    idle(4);
    step(0, 0, 1);
    check("rst_mid_lock", int'(lockout), 0);
    idle(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lock_supervisor.md
Name: lock_supervisor

Overview:
- Downstream consumer of the serial combination-lock FSM's `openlock` and `alarm` outputs.
- Turns single-cycle unlock grants into a timed door-actuator pulse.
- Counts failed attempts and, after MAX_FAILS of them, enters a timed lockout. During lockout it sounds the siren and holds the lock FSM in reset through `lock_rst`.

Parameters:
MAX_FAILS, 3, alarm events that trigger lockout (1..2**CNT_W-1)
UNLOCK_HOLD, 8, cycles door_unlock stays high per grant (>=1)
LOCKOUT_CYCLES, 16, cycles spent in lockout (>=1)
CNT_W, 8, width of fail counter and internal timer; must hold MAX_FAILS, UNLOCK_HOLD-1 and LOCKOUT_CYCLES-1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
openlock  input  1  unlock grant from lock FSM (level, may be combinational)
alarm  input  1  wrong-code indication from lock FSM (level, may be combinational)
door_unlock  output  1  door actuator drive, registered
siren  output  1  siren drive, registered
lockout  output  1  lockout status, registered
lock_rst  output  1  reset request to lock FSM, registered
fail_count  output  CNT_W  consecutive failed attempts since last grant or lockout, registered

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port `clk`, reset port `rst`.
- Reset: on any clk edge with rst=1:
  - state=IDLE; timer=0; fail_count=0.
  - open_prev=0; alarm_prev=0.
  - door_unlock=0; siren=0; lockout=0; lock_rst=0.
  - rst overrides everything, including mid-unlock and mid-lockout.
- Edge detection: open_prev and alarm_prev register the inputs every cycle, in all states.
  - open_rise = openlock & ~open_prev.
  - alarm_rise = alarm & ~alarm_prev.
  - A held-high level counts as one event only.
- Latency: an event sampled at edge N changes the outputs immediately after edge N. All outputs come straight from flops.
- Simultaneous events: if open_rise and alarm_rise occur in the same cycle, alarm_rise wins and open_rise is discarded.
- State IDLE (all outputs 0 except fail_count):
  - alarm_rise with fail_count+1 < MAX_FAILS: fail_count += 1; stay in IDLE.
  - alarm_rise with fail_count+1 == MAX_FAILS: go to LOCKOUT; timer = LOCKOUT_CYCLES-1; fail_count = 0.
  - open_rise (no alarm_rise): go to UNLOCKED; timer = UNLOCK_HOLD-1; fail_count = 0.
- State UNLOCKED (door_unlock=1):
  - timer decrements each cycle; on a cycle where timer==0 and no event, go to IDLE.
  - door_unlock is therefore high for exactly UNLOCK_HOLD cycles.
  - open_rise reloads timer to UNLOCK_HOLD-1 (extends the pulse).
  - alarm_rise aborts immediately: go to IDLE, door_unlock=0, and apply the IDLE alarm_rise rule (count, or lockout if the threshold is reached).
- State LOCKOUT (lockout=1, siren=1, lock_rst=1):
  - Edges on openlock/alarm are ignored; prev registers keep tracking, so no stale edge fires on exit.
  - timer decrements; when timer==0, go to IDLE next edge.
  - All three flags are high for exactly LOCKOUT_CYCLES cycles.
- Encoding and width rules:
  - 2-bit binary state encoding; value 3 is illegal and recovers to IDLE with outputs 0.
  - Timer and fail_count are unsigned CNT_W bits and never wrap, since they are cleared on reaching their thresholds.

Test Plan:
- Reset mid-lockout: drive 3 alarm pulses, then rst=1 for 1 cycle during LOCKOUT -> next cycle all outputs 0, fail_count=0, state IDLE.
- Grant: openlock high 1 cycle at edge 10 -> door_unlock=1 for cycles 11..18 (8 cycles), then 0; fail_count=0 throughout.
- Lockout: 3 separate 1-cycle alarm pulses, each followed by a low cycle -> fail_count goes 1, 2, then 0. siren, lockout and lock_rst are high for exactly 16 cycles, then all 0.
- Held level: alarm held high 10 cycles -> fail_count=1 only; no lockout.
- Extend and abort:
  - openlock pulse, then a second openlock pulse 5 cycles later -> door_unlock high for 5+8 cycles total.
  - Repeat with an alarm pulse at cycle 3 of the unlock -> door_unlock drops the next cycle and fail_count=1.
- Ignored input during lockout: openlock and alarm toggle during LOCKOUT -> no effect; exit at exactly 16 cycles; no event fires on the first IDLE cycle. Simultaneous openlock/alarm rise in IDLE -> counted as a fail, door_unlock stays 0.
